// File: rtl/matmul_pkg.sv
// Shared types and width helpers for the matmul tile engine.
package matmul_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MAC,
        LAST,
        WRITE,
        DONE
    } state_t;

    // Address width for a memory of the given depth; never narrower than one bit.
    function automatic int addr_w(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

    // C element width: full product plus log2(N) growth bits for the N-term sum.
    function automatic int c_width(input int dw, input int n);
        return 2 * dw + $clog2(n);
    endfunction

endpackage

// File: rtl/matmul_mac_lane.sv
// One signed multiply-accumulate lane: loads the first product of a dot product, accumulates the rest.
module matmul_mac_lane
    import matmul_pkg::*;
#(
    parameter int DW = 8,
    parameter int CW = 19
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 vld_p0,
    input  logic                 load_p0,
    input  logic signed [DW-1:0] a_p0,
    input  logic signed [DW-1:0] b_p0,
    output logic signed [CW-1:0] acc_p1
);

    logic signed [2*DW-1:0] prod_p0;
    logic signed [CW-1:0]   prod_ext_p0;

    assign prod_p0     = a_p0 * b_p0;
    assign prod_ext_p0 = CW'(prod_p0);

    // p0 -> p1: RAM data to accumulator
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_p1 <= '0;
        end else if (vld_p0) begin
            acc_p1 <= load_p0 ? prod_ext_p0 : acc_p1 + prod_ext_p0;
        end
    end

endmodule

// File: rtl/matmul_tile_engine.sv
// Signed NxN column-major matrix multiply C = A*B using LANES MAC lanes per tile.
// Optional MATMUL_PERF_COUNT_EN enables the cycle_total / cycle_compute counters.
module matmul_tile_engine
    import matmul_pkg::*;
#(
    parameter  int N     = 8,
    parameter  int DW    = 8,
    parameter  int LANES = 8,
    localparam int CW    = c_width(DW, N),
    localparam int AW_A  = addr_w(N * N / LANES),
    localparam int AW_C  = addr_w(N * N)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [AW_A-1:0]       a_addr,
    input  logic [LANES*DW-1:0]   a_rdata,
    output logic [AW_C-1:0]       b_addr,
    input  logic [DW-1:0]         b_rdata,
    output logic                  c_we,
    output logic [AW_C-1:0]       c_addr,
    output logic signed [CW-1:0]  c_wdata,
    output logic [15:0]           cycle_total,
    output logic [15:0]           cycle_compute
);

    localparam int KW      = addr_w(N);
    localparam int RBW     = addr_w(N / LANES);
    localparam int MW      = addr_w(LANES);
    localparam int RB_LAST = N / LANES - 1;

    state_t state, state_nxt;

    logic [KW-1:0]  k;
    logic [KW-1:0]  j;
    logic [RBW-1:0] rb;
    logic [MW-1:0]  m;
    logic [KW-1:0]  k_p0;
    logic           vld_p0;
    logic           load_p0;
    logic           k_last, m_last, rb_last, j_last;
    logic signed [CW-1:0] acc_p1 [LANES];

    assign k_last  = (k == KW'(N - 1));
    assign j_last  = (j == KW'(N - 1));
    assign rb_last = (rb == RBW'(RB_LAST));
    assign m_last  = (m == MW'(LANES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = MAC;
            MAC:     if (k_last) state_nxt = LAST;
            LAST:    state_nxt = WRITE;
            WRITE:   if (m_last) state_nxt = (j_last && rb_last) ? DONE : MAC;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state == MAC) || (state == LAST) || (state == WRITE);
        done    = (state == DONE);
        c_we    = (state == WRITE);
        a_addr  = '0;
        b_addr  = '0;
        c_addr  = '0;
        c_wdata = '0;
        if (state == MAC) begin
            a_addr = AW_A'(int'(k) * (N / LANES) + int'(rb));
            b_addr = AW_C'(int'(k) + N * int'(j));
        end
        if (state == WRITE) begin
            c_addr  = AW_C'(int'(rb) * LANES + int'(m) + N * int'(j));
            c_wdata = acc_p1[m];
        end
    end

    // Tile sequencing: k walks the dot product, m the writeback, rb then j select the tile.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k  <= '0;
            j  <= '0;
            rb <= '0;
            m  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        k  <= '0;
                        j  <= '0;
                        rb <= '0;
                        m  <= '0;
                    end
                end
                MAC: k <= k_last ? '0 : k + 1'b1;
                WRITE: begin
                    m <= m_last ? '0 : m + 1'b1;
                    if (m_last) begin
                        if (rb_last) begin
                            rb <= '0;
                            j  <= j_last ? '0 : j + 1'b1;
                        end else begin
                            rb <= rb + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // p0: RAM read data returns one cycle after the address, tagged with its k
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p0 <= 1'b0;
            k_p0   <= '0;
        end else begin
            vld_p0 <= (state == MAC);
            k_p0   <= k;
        end
    end

    assign load_p0 = (k_p0 == '0);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        matmul_mac_lane #(
            .DW(DW),
            .CW(CW)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .vld_p0 (vld_p0),
            .load_p0(load_p0),
            .a_p0   (a_rdata[i*DW +: DW]),
            .b_p0   (b_rdata),
            .acc_p1 (acc_p1[i])
        );
    end

`ifdef MATMUL_PERF_COUNT_EN
    logic [15:0] total_q;
    logic [15:0] compute_q;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Total spans MAC through DONE; compute covers only the MAC and LAST states.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            total_q   <= '0;
            compute_q <= '0;
        end else if (state == IDLE) begin
            if (start) begin
                total_q   <= '0;
                compute_q <= '0;
            end
        end else begin
            total_q <= sat_inc(total_q);
            if ((state == MAC) || (state == LAST)) compute_q <= sat_inc(compute_q);
        end
    end

    assign cycle_total   = total_q;
    assign cycle_compute = compute_q;
`else
    assign cycle_total   = 16'd0;
    assign cycle_compute = 16'd0;
`endif

endmodule

// File: tb/tb_matmul_tile_engine.sv
// Directed bench for matmul_tile_engine at N=8, LANES=2 with behavioural A/B/C RAMs.
module tb_matmul_tile_engine;

    localparam int N     = 8;
    localparam int DW    = 8;
    localparam int LANES = 2;
    localparam int CW    = 19;
    localparam int BUSY_CYC = 352;   // 32 tiles * (8 + 1 + 2)
`ifdef MATMUL_PERF_COUNT_EN
    localparam int EXP_TOT = 353;    // busy cycles plus the DONE cycle
    localparam int EXP_CMP = 288;    // 32 tiles * (8 MAC + 1 LAST)
`else
    localparam int EXP_TOT = 0;
    localparam int EXP_CMP = 0;
`endif

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 start = 1'b0;
    logic                 busy, done, c_we;
    logic [4:0]           a_addr;
    logic [LANES*DW-1:0]  a_rdata;
    logic [5:0]           b_addr;
    logic [DW-1:0]        b_rdata;
    logic [5:0]           c_addr;
    logic signed [CW-1:0] c_wdata;
    logic [15:0]          cycle_total, cycle_compute;

    always #5 clk = ~clk;

    matmul_tile_engine #(.N(N), .DW(DW), .LANES(LANES)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .a_addr       (a_addr),
        .a_rdata      (a_rdata),
        .b_addr       (b_addr),
        .b_rdata      (b_rdata),
        .c_we         (c_we),
        .c_addr       (c_addr),
        .c_wdata      (c_wdata),
        .cycle_total  (cycle_total),
        .cycle_compute(cycle_compute)
    );

    logic signed [DW-1:0] a_mem [N*N];
    logic signed [DW-1:0] b_mem [N*N];
    logic signed [CW-1:0] c_mem [N*N];
    int we_cnt = 0;
    int done_cnt = 0;
    int checks = 0;
    int failures = 0;

    always @(posedge clk) begin
        for (int i = 0; i < LANES; i++) a_rdata[i*DW +: DW] <= a_mem[int'(a_addr) * LANES + i];
        b_rdata <= b_mem[b_addr];
        if (c_we) begin
            c_mem[c_addr] <= c_wdata;
            we_cnt <= we_cnt + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int gold(input int r, input int col);
        int s = 0;
        for (int kk = 0; kk < N; kk++) s += int'(a_mem[r + N*kk]) * int'(b_mem[kk + N*col]);
        return s;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < N*N; i++) begin
            a_mem[i] = 8'($urandom_range(0, 255));
            b_mem[i] = 8'($urandom_range(0, 255));
        end
    endtask

    task automatic check_gold(input string pfx);
        for (int i = 0; i < N*N; i++) check($sformatf("%s_c%0d", pfx, i), c_mem[i], gold(i % N, i / N));
    endtask

    // Starts a run and follows it to done; pulse_at re-pulses start at that busy-cycle index.
    task automatic run_mm(input string pfx, input int pulse_at, input bit hold_start, output int bcyc);
        bit ok = 1'b0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) if (!hold_start) start = 1'b0;
        check({pfx, "_busy_first"}, busy, 1);
        check({pfx, "_a_addr_k0"}, a_addr, 0);
        check({pfx, "_b_addr_k0"}, b_addr, 0);
        bcyc = 0;
        for (int t = 0; t < 2000; t++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            if (busy) bcyc++;
            if (bcyc == 2 && t == 1) begin
                check({pfx, "_a_addr_k1"}, a_addr, N / LANES);
                check({pfx, "_b_addr_k1"}, b_addr, 1);
            end
            if (bcyc == 10 && t == 9) begin
                check({pfx, "_c_we_tile0"}, c_we, 1);
                check({pfx, "_c_addr_tile0"}, c_addr, 0);
            end
            if (bcyc == 21 && t == 20) check({pfx, "_c_addr_tile1"}, c_addr, 2);
            if (!hold_start) start = (busy && (bcyc - 1 == pulse_at));
            @(negedge clk);
        end
        check({pfx, "_done_seen"}, ok, 1);
        @(negedge clk);
        check({pfx, "_done_after"}, done, 0);
        check({pfx, "_busy_after"}, busy, 0);
    endtask

    initial begin
        int bc;
        int d0, w0;

        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_c_we", c_we, 0);
        check("rst_a_addr", a_addr, 0);
        check("rst_b_addr", b_addr, 0);
        check("rst_c_addr", c_addr, 0);
        check("rst_c_wdata", c_wdata, 0);
        check("rst_total", cycle_total, 0);
        check("rst_compute", cycle_compute, 0);
        rst = 1'b1;
        @(negedge clk);

        // Identity A: C must equal B
        for (int i = 0; i < N*N; i++) begin
            a_mem[i] = ((i % N) == (i / N)) ? 8'sd1 : 8'sd0;
            b_mem[i] = 8'($urandom_range(0, 255));
        end
        d0 = done_cnt;
        w0 = we_cnt;
        run_mm("t1", -1, 1'b0, bc);
        check("t1_busy_cycles", bc, BUSY_CYC);
        check("t1_cycle_total", cycle_total, EXP_TOT);
        check("t1_cycle_compute", cycle_compute, EXP_CMP);
        check("t1_we_count", we_cnt - w0, N*N);
        check("t1_done_pulses", done_cnt - d0, 1);
        for (int i = 0; i < N*N; i++) check($sformatf("t1_c%0d", i), c_mem[i], b_mem[i]);

        // Worst-case magnitude: 8 * (-128 * -128) = 131072
        for (int i = 0; i < N*N; i++) begin
            a_mem[i] = -8'sd128;
            b_mem[i] = -8'sd128;
        end
        run_mm("t2", -1, 1'b0, bc);
        for (int i = 0; i < N*N; i++) check($sformatf("t2_c%0d", i), c_mem[i], 131072);

        // Random data, start re-pulsed during WRITE of tile 3 (busy index 42)
        fill_random();
        d0 = done_cnt;
        w0 = we_cnt;
        run_mm("t3", 42, 1'b0, bc);
        check("t3_busy_cycles", bc, BUSY_CYC);
        check("t3_done_pulses", done_cnt - d0, 1);
        check("t3_we_count", we_cnt - w0, N*N);
        check("t3_cycle_total", cycle_total, EXP_TOT);
        check_gold("t3");

        // Start held high restarts from IDLE; then reset in MAC of tile 2
        fill_random();
        run_mm("t4", -1, 1'b1, bc);
        @(negedge clk);
        check("t4_restart_busy", busy, 1);
        start = 1'b0;
        repeat (24) @(negedge clk);
        check("t4_pre_rst_busy", busy, 1);
        rst = 1'b0;
        #1;
        check("t4_rst_busy", busy, 0);
        check("t4_rst_done", done, 0);
        check("t4_rst_c_we", c_we, 0);
        check("t4_rst_a_addr", a_addr, 0);
        @(posedge clk);
        #1;
        check("t4_rst_busy_edge", busy, 0);
        check("t4_rst_total", cycle_total, 0);
        @(negedge clk) rst = 1'b1;

        // Fresh run after abort must produce a complete, correct C
        fill_random();
        w0 = we_cnt;
        run_mm("t5", -1, 1'b0, bc);
        check("t5_busy_cycles", bc, BUSY_CYC);
        check("t5_we_count", we_cnt - w0, N*N);
        check("t5_cycle_compute", cycle_compute, EXP_CMP);
        check_gold("t5");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
